// File: rtl/aes_mix_columns_iter.sv
// Iterative AES MixColumns/InvMixColumns over the full 4x4 state, ColsPerCycle columns per beat.
// Optional AES_MIXCOL_ZEROIZE_EN: clear state and op registers on the output handshake or on flush.

package aes_pkg;
    typedef enum logic [1:0] {
        CIPH_FWD = 2'b01,
        CIPH_INV = 2'b10
    } ciph_op_e;
endpackage

module aes_mix_columns_iter
    import aes_pkg::*;
#(
    parameter int ColsPerCycle = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  ciph_op_e              op_i,
    input  logic [3:0][3:0][7:0]  data_i,
    input  logic                  flush_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [3:0][3:0][7:0]  data_o,
    output logic                  err_o
);

    localparam int         NumBeats = 4 / ColsPerCycle;
    localparam logic [1:0] LastBeat = 2'(NumBeats - 1);

    if ((ColsPerCycle != 1) && (ColsPerCycle != 2) && (ColsPerCycle != 4)) begin : gen_bad_cfg
        $error("aes_mix_columns_iter: ColsPerCycle must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           beat_q, beat_d;
    ciph_op_e             op_q;
    logic                 op_err_q;
    logic [3:0][3:0][7:0] data_q;
    logic [3:0][3:0][7:0] data_mixed;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Inverse reuses the forward network: InvMix(a) = Mix(a) ^ Mix({u,v,u,v}).
    function automatic logic [3:0][7:0] mix_column(input logic [3:0][7:0] a, input logic inv);
        logic [3:0][7:0] y;
        logic [7:0]      u, v, z;
        for (int r = 0; r < 4; r++) begin
            y[r] = xtime(a[2'(r)] ^ a[2'(r + 1)]) ^ a[2'(r + 1)] ^ a[2'(r + 2)] ^ a[2'(r + 3)];
        end
        u = xtime(xtime(a[0] ^ a[2]));
        v = xtime(xtime(a[1] ^ a[3]));
        z = xtime(u ^ v);
        if (inv) begin
            y[0] = y[0] ^ z ^ u;
            y[1] = y[1] ^ z ^ v;
            y[2] = y[2] ^ z ^ u;
            y[3] = y[3] ^ z ^ v;
        end
        return y;
    endfunction

    logic [ColsPerCycle-1:0][1:0]      col_idx;
    logic [ColsPerCycle-1:0][3:0][7:0] col_out;

    for (genvar k = 0; k < ColsPerCycle; k++) begin : gen_col
        logic [3:0][7:0] col_in;

        assign col_idx[k] = 2'(int'(beat_q) * ColsPerCycle + k);

        always_comb begin
            col_in = '0;
            for (int r = 0; r < 4; r++) begin
                col_in[r] = data_q[r][col_idx[k]];
            end
        end

        assign col_out[k] = mix_column(col_in, op_q == CIPH_INV);
    end

    always_comb begin
        data_mixed = data_q;
        for (int k = 0; k < ColsPerCycle; k++) begin
            for (int r = 0; r < 4; r++) begin
                data_mixed[r][col_idx[k]] = col_out[k][r];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        if (flush_i) begin
            state_d = IDLE;
            beat_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        state_d = BUSY;
                        beat_d  = '0;
                    end
                end
                BUSY: begin
                    beat_d = beat_q + 2'd1;
                    if (beat_q == LastBeat) begin
                        state_d = DONE;
                        beat_d  = '0;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // An invalid op still walks every beat so result timing never depends on op.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q   <= '0;
            op_q     <= CIPH_FWD;
            op_err_q <= 1'b0;
        end else if (flush_i) begin
            op_err_q <= 1'b0;
`ifdef AES_MIXCOL_ZEROIZE_EN
            data_q   <= '0;
            op_q     <= ciph_op_e'(2'b00);
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        data_q   <= data_i;
                        op_q     <= op_i;
                        op_err_q <= !(op_i inside {CIPH_FWD, CIPH_INV});
                    end
                end
                BUSY: data_q <= data_mixed;
                DONE: begin
`ifdef AES_MIXCOL_ZEROIZE_EN
                    if (out_ready_i) begin
                        data_q <= '0;
                        op_q   <= ciph_op_e'(2'b00);
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign in_ready_o  = (state_q == IDLE) && !rst_i;
    assign out_valid_o = (state_q == DONE);
    assign err_o       = out_valid_o && op_err_q;
    assign data_o      = (out_valid_o && op_err_q) ? '0 : data_q;

endmodule

// File: tb/tb_aes_mix_columns_iter.sv
// Self-checking bench for aes_mix_columns_iter: three instances (4, 1 and 2 columns per cycle)
// driven by directed steps, with a scoreboard queue of expected results.

module tb_aes_mix_columns_iter;
    import aes_pkg::*;

    typedef logic [3:0][3:0][7:0] state_t;
    typedef logic [3:0][7:0]      col_t;

    typedef struct {
        int     idx;
        state_t data;
        logic   err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic     clk_i = 1'b0;
    logic     rst_i = 1'b1;
    logic     in_valid[3];
    logic     in_ready[3];
    logic     flush[3];
    logic     out_valid[3];
    logic     out_ready[3];
    logic     err[3];
    ciph_op_e op[3];
    state_t   din[3];
    state_t   dout[3];

    always #5 clk_i = ~clk_i;

    aes_mix_columns_iter #(.ColsPerCycle(4)) u_dut4 (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .op_i(op[0]), .data_i(din[0]), .flush_i(flush[0]), .out_valid_o(out_valid[0]),
        .out_ready_i(out_ready[0]), .data_o(dout[0]), .err_o(err[0])
    );

    aes_mix_columns_iter #(.ColsPerCycle(1)) u_dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .op_i(op[1]), .data_i(din[1]), .flush_i(flush[1]), .out_valid_o(out_valid[1]),
        .out_ready_i(out_ready[1]), .data_o(dout[1]), .err_o(err[1])
    );

    aes_mix_columns_iter #(.ColsPerCycle(2)) u_dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
        .op_i(op[2]), .data_i(din[2]), .flush_i(flush[2]), .out_valid_o(out_valid[2]),
        .out_ready_i(out_ready[2]), .data_o(dout[2]), .err_o(err[2])
    );

    function automatic int num_beats(input int idx);
        return (idx == 0) ? 1 : (idx == 1) ? 4 : 2;
    endfunction

    function automatic col_t mk_col(input logic [7:0] b0, input logic [7:0] b1,
                                    input logic [7:0] b2, input logic [7:0] b3);
        return {b3, b2, b1, b0};
    endfunction

    function automatic state_t mk_state(input col_t c0, input col_t c1, input col_t c2, input col_t c3);
        state_t s;
        col_t   cols[4];
        cols[0] = c0; cols[1] = c1; cols[2] = c2; cols[3] = c3;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                s[r][c] = cols[c][r];
            end
        end
        return s;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    // Straight coefficient-matrix reference, independent of the xtime/correction structure.
    function automatic state_t model(input state_t s, input logic inv);
        state_t     o;
        logic [7:0] coef[4];
        logic [7:0] acc;
        if (inv) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gmul(coef[j], s[(r + j) % 4][c]);
                end
                o[r][c] = acc;
            end
        end
        return o;
    endfunction

    function automatic state_t rand_state();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one state for a single cycle starting at a negedge; returns at the negedge after the handshake edge.
    task automatic applyStimulus(input int idx, input state_t s, input ciph_op_e o,
                                 input state_t exp_data, input logic exp_err);
        exp_t e;
        checkVal("in_ready_before_push", in_ready[idx], 1'b1);
        in_valid[idx] = 1'b1;
        din[idx]      = s;
        op[idx]       = o;
        e.idx  = idx;
        e.data = exp_data;
        e.err  = exp_err;
        sb.push_back(e);
        @(negedge clk_i);
        in_valid[idx] = 1'b0;
    endtask

    task automatic checkOutput(input int idx, input string tag, input int hold, input bit release_out);
        exp_t e;
        int   lat;
        lat = 1;
        while (!out_valid[idx] && lat < 50) begin
            @(negedge clk_i);
            lat++;
        end
        checkVal({tag, "_latency"}, lat, num_beats(idx) + 1);
        checkVal({tag, "_sb_size"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkVal({tag, "_data"}, dout[idx], e.data);
            checkVal({tag, "_err"}, err[idx], e.err);
            checkVal({tag, "_in_ready_done"}, in_ready[idx], 1'b0);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk_i);
                checkVal({tag, "_hold_valid"}, out_valid[idx], 1'b1);
                checkVal({tag, "_hold_data"}, dout[idx], e.data);
                checkVal({tag, "_hold_in_ready"}, in_ready[idx], 1'b0);
            end
        end
        if (release_out) begin
            out_ready[idx] = 1'b1;
            @(negedge clk_i);
            out_ready[idx] = 1'b0;
            checkVal({tag, "_valid_after_release"}, out_valid[idx], 1'b0);
            checkVal({tag, "_in_ready_after_release"}, in_ready[idx], 1'b1);
        end
    endtask

    initial begin
        state_t s, st[3];
        exp_t   e;
        int     sent, got, last, cyc;

        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            flush[i]     = 1'b0;
            out_ready[i] = 1'b0;
            op[i]        = CIPH_FWD;
            din[i]       = '0;
        end

        // Reset state
        repeat (2) @(negedge clk_i);
        for (int i = 0; i < 3; i++) begin
            checkVal("rst_in_ready", in_ready[i], 1'b0);
            checkVal("rst_out_valid", out_valid[i], 1'b0);
            checkVal("rst_err", err[i], 1'b0);
            checkVal("rst_data", dout[i], '0);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
        for (int i = 0; i < 3; i++) checkVal("post_rst_in_ready", in_ready[i], 1'b1);

        $display("[TB] test 1: ColsPerCycle=4 forward");
        s = mk_state(mk_col(8'hdb, 8'h13, 8'h53, 8'h45), mk_col(8'hdb, 8'h13, 8'h53, 8'h45),
                     mk_col(8'hdb, 8'h13, 8'h53, 8'h45), mk_col(8'hdb, 8'h13, 8'h53, 8'h45));
        applyStimulus(0, s, CIPH_FWD,
                      mk_state(mk_col(8'h8e, 8'h4d, 8'ha1, 8'hbc), mk_col(8'h8e, 8'h4d, 8'ha1, 8'hbc),
                               mk_col(8'h8e, 8'h4d, 8'ha1, 8'hbc), mk_col(8'h8e, 8'h4d, 8'ha1, 8'hbc)), 1'b0);
        checkOutput(0, "t1", 0, 1);

        $display("[TB] test 2: ColsPerCycle=1 inverse");
        s = mk_state(mk_col(8'h8e, 8'h4d, 8'ha1, 8'hbc), mk_col(8'h9f, 8'hdc, 8'h58, 8'h9d),
                     mk_col(8'h01, 8'h01, 8'h01, 8'h01), mk_col(8'h4d, 8'h7e, 8'hbd, 8'hf8));
        applyStimulus(1, s, CIPH_INV,
                      mk_state(mk_col(8'hdb, 8'h13, 8'h53, 8'h45), mk_col(8'hf2, 8'h0a, 8'h22, 8'h5c),
                               mk_col(8'h01, 8'h01, 8'h01, 8'h01), mk_col(8'h2d, 8'h26, 8'h31, 8'h4c)), 1'b0);
        checkOutput(1, "t2", 0, 1);

        $display("[TB] test 3: ColsPerCycle=2 forward with backpressure");
        s = mk_state(mk_col(8'hd4, 8'hd4, 8'hd4, 8'hd5), mk_col(8'hc6, 8'hc6, 8'hc6, 8'hc6),
                     mk_col(8'h2d, 8'h26, 8'h31, 8'h4c), mk_col(8'hf2, 8'h0a, 8'h22, 8'h5c));
        applyStimulus(2, s, CIPH_FWD,
                      mk_state(mk_col(8'hd5, 8'hd5, 8'hd7, 8'hd6), mk_col(8'hc6, 8'hc6, 8'hc6, 8'hc6),
                               mk_col(8'h4d, 8'h7e, 8'hbd, 8'hf8), mk_col(8'h9f, 8'hdc, 8'h58, 8'h9d)), 1'b0);
        checkOutput(2, "t3", 7, 1);

        $display("[TB] test 4: invalid op");
        applyStimulus(2, rand_state(), ciph_op_e'(2'b11), '0, 1'b1);
        checkOutput(2, "t4", 1, 1);
        s = rand_state();
        applyStimulus(0, s, CIPH_INV, model(s, 1'b1), 1'b0);
        checkOutput(0, "t4_fwd_after_err", 0, 1);

        $display("[TB] test 5: flush in BUSY beat 1");
        applyStimulus(1, rand_state(), CIPH_FWD, '0, 1'b0);
        @(negedge clk_i);
        flush[1] = 1'b1;
        @(negedge clk_i);
        flush[1] = 1'b0;
        void'(sb.pop_back());
        checkVal("t5_flush_valid", out_valid[1], 1'b0);
        checkVal("t5_flush_in_ready", in_ready[1], 1'b1);
        checkVal("t5_flush_err", err[1], 1'b0);
`ifdef AES_MIXCOL_ZEROIZE_EN
        checkVal("t5_flush_zeroize", dout[1], '0);
`endif
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            checkVal("t5_no_valid", out_valid[1], 1'b0);
        end
        s = rand_state();
        applyStimulus(1, s, CIPH_INV, model(s, 1'b1), 1'b0);
        checkOutput(1, "t5_after_flush", 0, 1);
`ifdef AES_MIXCOL_ZEROIZE_EN
        checkVal("t5_idle_zeroize", dout[1], '0);
`endif

        $display("[TB] test 6: reset in DONE, then streaming");
        s = rand_state();
        applyStimulus(0, s, CIPH_FWD, model(s, 1'b0), 1'b0);
        checkOutput(0, "t6", 2, 0);
        rst_i = 1'b1;
        @(negedge clk_i);
        checkVal("t6_rst_valid", out_valid[0], 1'b0);
        checkVal("t6_rst_in_ready", in_ready[0], 1'b0);
        checkVal("t6_rst_data", dout[0], '0);
        rst_i = 1'b0;
        @(negedge clk_i);
        checkVal("t6_post_rst_in_ready", in_ready[0], 1'b1);
        checkVal("t6_post_rst_valid", out_valid[0], 1'b0);

        for (int i = 0; i < 3; i++) st[i] = rand_state();
        out_ready[1] = 1'b1;
        sent = 0; got = 0; last = -1; cyc = 0;
        while (got < 3 && cyc < 200) begin
            if (out_valid[1]) begin
                checkVal("t6_stream_sb_size", (sb.size() > 0), 1'b1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checkVal("t6_stream_data", dout[1], e.data);
                    checkVal("t6_stream_err", err[1], e.err);
                end
                if (last >= 0) checkVal("t6_stream_period", cyc - last, num_beats(1) + 2);
                last = cyc;
                got++;
            end
            if (in_ready[1] && sent < 3) begin
                in_valid[1] = 1'b1;
                din[1]      = st[sent];
                op[1]       = (sent == 1) ? CIPH_INV : CIPH_FWD;
                e.idx  = 1;
                e.data = model(st[sent], sent == 1);
                e.err  = 1'b0;
                sb.push_back(e);
                sent++;
            end else begin
                in_valid[1] = 1'b0;
            end
            @(negedge clk_i);
            cyc++;
        end
        in_valid[1]  = 1'b0;
        out_ready[1] = 1'b0;
        checkVal("t6_stream_count", got, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
